// File: rtl/video_tpg.sv
// Video test-pattern generator: free-running 720p-class raster timing with
// colour-bar, grid, solid and gradient RGB565 patterns. Pattern selection is
// frame-synchronous; every output is registered one cycle after the counters.
module video_tpg #(
    parameter int H_DISP  = 1280,
    parameter int H_FRONT = 110,
    parameter int H_SYNC  = 40,
    parameter int H_BACK  = 220,
    parameter int V_DISP  = 720,
    parameter int V_FRONT = 5,
    parameter int V_SYNC  = 5,
    parameter int V_BACK  = 20
) (
    input  logic        video_clk,
    input  logic        video_rst,
    input  logic        tpg_en,
    input  logic [1:0]  tpg_mode,
    input  logic [15:0] tpg_color,
    output logic        tpg_hs,
    output logic        tpg_vs,
    output logic        tpg_de,
    output logic [15:0] tpg_data,
    output logic [15:0] tpg_frame_cnt
);

    // Raster geometry; counters are 12 bits, enough for totals up to 4095.
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [11:0] H_LAST_C   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST_C   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_C   = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_C   = 12'(V_SYNC);
    localparam logic [11:0] HA_START_C = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HA_END_C   = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] VA_START_C = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VA_END_C   = 12'(V_SYNC + V_BACK + V_DISP);
    localparam logic [9:0]  HA_X_C     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  VA_Y_C     = 10'(V_SYNC + V_BACK);
    localparam logic [11:0] BAR_LAST_C = 12'((H_DISP / 8) - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] seg_q, seg_d;
    logic [2:0]  bar_q, bar_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] color_q, color_d;
    logic [15:0] frame_q, frame_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [15:0] data_q, data_d;

    logic        run_s;
    logic        h_last_s;
    logic        v_last_s;
    logic        frame_end_s;
    logic        h_act_s;
    logic        v_act_s;
    logic        act_s;
    logic        latch_s;
    logic [9:0]  x_s;
    logic [9:0]  y_s;
    logic [15:0] pix_s;

    assign run_s       = (state_q == ST_RUN);
    assign h_last_s    = (h_cnt_q == H_LAST_C);
    assign v_last_s    = (v_cnt_q == V_LAST_C);
    assign frame_end_s = run_s & h_last_s & v_last_s;
    assign h_act_s     = (h_cnt_q >= HA_START_C) && (h_cnt_q < HA_END_C);
    assign v_act_s     = (v_cnt_q >= VA_START_C) && (v_cnt_q < VA_END_C);
    assign act_s       = run_s & h_act_s & v_act_s;
    // Shadow registers pick up new settings on RUN entry and at each frame boundary.
    assign latch_s     = ((state_q == ST_IDLE) & tpg_en) | frame_end_s;
    // Only the low 10 bits of x/y feed the patterns, so modulo-1024 subtraction suffices.
    assign x_s         = h_cnt_q[9:0] - HA_X_C;
    assign y_s         = v_cnt_q[9:0] - VA_Y_C;

    // Next-state logic: leave RUN only once the current frame has fully completed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tpg_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_end_s && !tpg_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Raster counters: held at zero in IDLE, free-running with wrap in RUN.
    always_comb begin
        h_cnt_d = 12'd0;
        v_cnt_d = 12'd0;
        if (run_s) begin
            if (h_last_s) begin
                h_cnt_d = 12'd0;
                if (v_last_s) begin
                    v_cnt_d = 12'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 12'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                v_cnt_d = v_cnt_q;
            end
        end else begin
            h_cnt_d = 12'd0;
            v_cnt_d = 12'd0;
        end
    end

    // Colour-bar segment counter: cleared at line start, steps the bar index every H_DISP/8 active pixels.
    always_comb begin
        seg_d = seg_q;
        bar_d = bar_q;
        if (!run_s || h_last_s) begin
            seg_d = 12'd0;
            bar_d = 3'd0;
        end else if (h_act_s) begin
            if (seg_q == BAR_LAST_C) begin
                seg_d = 12'd0;
                if (bar_q != 3'd7) begin
                    bar_d = bar_q + 3'd1;
                end else begin
                    bar_d = bar_q;
                end
            end else begin
                seg_d = seg_q + 12'd1;
            end
        end else begin
            seg_d = seg_q;
        end
    end

    // Shadow mode/colour and the completed-frame counter.
    always_comb begin
        mode_d  = mode_q;
        color_d = color_q;
        frame_d = frame_q;
        if (latch_s) begin
            mode_d  = tpg_mode;
            color_d = tpg_color;
        end else begin
            mode_d  = mode_q;
            color_d = color_q;
        end
        if (frame_end_s) begin
            frame_d = frame_q + 16'd1;
        end else begin
            frame_d = frame_q;
        end
    end

    // Pattern generation for the current pixel from the shadowed mode.
    always_comb begin
        pix_s = 16'h0000;
        case (mode_q)
            2'b00: begin
                case (bar_q)
                    3'd0:    pix_s = 16'hFFFF;
                    3'd1:    pix_s = 16'hFFE0;
                    3'd2:    pix_s = 16'h07FF;
                    3'd3:    pix_s = 16'h07E0;
                    3'd4:    pix_s = 16'hF81F;
                    3'd5:    pix_s = 16'hF800;
                    3'd6:    pix_s = 16'h001F;
                    default: pix_s = 16'h0000;
                endcase
            end
            2'b01: begin
                if ((x_s[4:0] == 5'd0) || (y_s[4:0] == 5'd0)) begin
                    pix_s = 16'hFFFF;
                end else begin
                    pix_s = 16'h0000;
                end
            end
            2'b10:   pix_s = color_q;
            2'b11:   pix_s = {x_s[9:5], y_s[9:4], frame_q[4:0]};
            default: pix_s = 16'h0000;
        endcase
    end

    // Output decode; everything is forced low outside RUN.
    always_comb begin
        hs_d   = run_s & (h_cnt_q < H_SYNC_C);
        vs_d   = run_s & (v_cnt_q < V_SYNC_C);
        de_d   = act_s;
        data_d = 16'h0000;
        if (act_s) begin
            data_d = pix_s;
        end else begin
            data_d = 16'h0000;
        end
    end

    // State, counters, shadows and registered outputs with synchronous reset.
    always_ff @(posedge video_clk) begin
        if (video_rst) begin
            state_q <= ST_IDLE;
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            seg_q   <= 12'd0;
            bar_q   <= 3'd0;
            mode_q  <= 2'b00;
            color_q <= 16'h0000;
            frame_q <= 16'h0000;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            seg_q   <= seg_d;
            bar_q   <= bar_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            frame_q <= frame_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            data_q  <= data_d;
        end
    end

    assign tpg_hs        = hs_q;
    assign tpg_vs        = vs_q;
    assign tpg_de        = de_q;
    assign tpg_data      = data_q;
    assign tpg_frame_cnt = frame_q;

endmodule

// File: tb/tb_video_tpg.sv
// Directed testbench for video_tpg using a reduced raster so several frames fit
// in a short run: 3+5+80+4 = 92 clocks per line, 2+3+66+2 = 73 lines per frame.
module tb_video_tpg;

    localparam int H_DISP  = 80;
    localparam int H_FRONT = 4;
    localparam int H_SYNC  = 3;
    localparam int H_BACK  = 5;
    localparam int V_DISP  = 66;
    localparam int V_FRONT = 2;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 3;
    localparam int HT      = 92;
    localparam int VT      = 73;
    localparam int FRAME   = HT * VT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;
    localparam int NFRAMES = 5;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] color;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] data;
    logic [15:0] fcnt;

    int n_checks;
    int n_errors;

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [15:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    video_tpg #(
        .H_DISP (H_DISP),
        .H_FRONT(H_FRONT),
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .V_DISP (V_DISP),
        .V_FRONT(V_FRONT),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK)
    ) dut (
        .video_clk    (clk),
        .video_rst    (rst),
        .tpg_en       (en),
        .tpg_mode     (mode),
        .tpg_color    (color),
        .tpg_hs       (hs),
        .tpg_vs       (vs),
        .tpg_de       (de),
        .tpg_data     (data),
        .tpg_frame_cnt(fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int f, input int x, input int y, input logic [15:0] exp, input string tag);
        vec_t v;
        v.f = f; v.x = x; v.y = y; v.exp = exp; v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        int p, f, r, v, h, x, y;
        int hs_rises, hs_first, hs_run;
        int vs_rises, vs_first;
        int hs_hi0, vs_hi0, de_run, bad_burst, idle_bad;
        int de_total[NFRAMES];
        int bursts[NFRAMES];
        logic prev_hs, prev_vs, prev_de;

        n_checks = 0; n_errors = 0;
        hs_rises = 0; hs_first = 0; hs_run = 0;
        vs_rises = 0; vs_first = 0;
        hs_hi0 = 0; vs_hi0 = 0; de_run = 0; bad_burst = 0; idle_bad = 0;
        for (int i = 0; i < NFRAMES; i++) begin
            de_total[i] = 0;
            bursts[i]   = 0;
        end
        prev_hs = 1'b0; prev_vs = 1'b0; prev_de = 1'b0;

        // colour bars, 10-pixel bars
        add_vec(0, 0, 0, 16'hFFFF, "bar_x0");
        add_vec(0, 9, 0, 16'hFFFF, "bar_x9");
        add_vec(0, 10, 0, 16'hFFE0, "bar_x10");
        add_vec(0, 25, 0, 16'h07FF, "bar_x25");
        add_vec(0, 35, 0, 16'h07E0, "bar_x35");
        add_vec(0, 45, 0, 16'hF81F, "bar_x45");
        add_vec(0, 55, 0, 16'hF800, "bar_x55");
        add_vec(0, 69, 0, 16'h001F, "bar_x69");
        add_vec(0, 70, 0, 16'h0000, "bar_x70");
        add_vec(0, 79, 0, 16'h0000, "bar_x79");
        add_vec(0, 10, 65, 16'hFFE0, "bar_y65_x10");
        // grid (mode changed during frame 0)
        add_vec(1, 0, 5, 16'hFFFF, "grid_0_5");
        add_vec(1, 32, 7, 16'hFFFF, "grid_32_7");
        add_vec(1, 33, 33, 16'h0000, "grid_33_33");
        add_vec(1, 5, 64, 16'hFFFF, "grid_5_64");
        add_vec(1, 5, 5, 16'h0000, "grid_5_5");
        add_vec(1, 0, 0, 16'hFFFF, "grid_0_0");
        // solid, colour changed to ABCD at (x=0,y=10) of frame 2
        add_vec(2, 0, 0, 16'h1234, "solid_0_0");
        add_vec(2, 1, 10, 16'h1234, "solid_after_chg");
        add_vec(2, 79, 65, 16'h1234, "solid_last");
        add_vec(3, 0, 0, 16'hABCD, "solid_next_0_0");
        add_vec(3, 40, 30, 16'hABCD, "solid_next_40_30");
        // gradient, frame_lsb = 4; tpg_en dropped at y=20
        add_vec(4, 0, 0, 16'h0004, "grad_0_0");
        add_vec(4, 32, 16, 16'h0824, "grad_32_16");
        add_vec(4, 79, 65, 16'h1084, "grad_79_65");

        rst = 1'b1; en = 1'b0; mode = 2'b00; color = 16'h0000;
        repeat (3) tick();
        check_val("rst_hs", {31'd0, hs}, 32'd0);
        check_val("rst_vs", {31'd0, vs}, 32'd0);
        check_val("rst_de", {31'd0, de}, 32'd0);
        check_val("rst_data", {16'd0, data}, 32'd0);
        check_val("rst_fcnt", {16'd0, fcnt}, 32'd0);
        rst = 1'b0;
        tick();
        check_val("idle_hs", {31'd0, hs}, 32'd0);

        en = 1'b1;
        tick();
        check_val("first_run_hs", {31'd0, hs}, 32'd0);
        mode = 2'b01;

        for (int idx = 1; idx <= NFRAMES * FRAME + 20; idx++) begin
            tick();
            p = idx - 1;
            if (p < NFRAMES * FRAME) begin
                f = p / FRAME;
                r = p % FRAME;
                v = r / HT;
                h = r % HT;
                if (p == 0) begin
                    check_val("hs_start", {31'd0, hs}, 32'd1);
                    check_val("vs_start", {31'd0, vs}, 32'd1);
                end
                // sync statistics
                if (hs && !prev_hs) begin
                    hs_rises++;
                    if (hs_rises == 1) hs_first = p;
                    if (hs_rises == 2) check_val("hs_period", p - hs_first, HT);
                end
                if (hs) hs_run++;
                if (!hs && prev_hs) begin
                    if (hs_rises == 1) check_val("hs_width", hs_run, H_SYNC);
                    hs_run = 0;
                end
                if (f == 0 && hs) hs_hi0++;
                if (f == 0 && vs) vs_hi0++;
                if (vs && !prev_vs) begin
                    vs_rises++;
                    if (vs_rises == 1) vs_first = p;
                    if (vs_rises == 2) check_val("vs_period", p - vs_first, FRAME);
                end
                // data-enable bursts
                if (de) begin
                    de_total[f]++;
                    de_run++;
                end
                if (!de && prev_de) begin
                    bursts[f]++;
                    if (de_run != H_DISP) bad_burst++;
                    de_run = 0;
                end
                // pixel vectors
                if (v >= VA && v < VA + V_DISP && h >= HA && h < HA + H_DISP) begin
                    x = h - HA;
                    y = v - VA;
                    foreach (vecs[i]) begin
                        if (vecs[i].f == f && vecs[i].x == x && vecs[i].y == y) begin
                            check_val(vecs[i].tag, {16'd0, data}, {16'd0, vecs[i].exp});
                        end
                    end
                end
                if (v == VA && h == HA) begin
                    check_val($sformatf("fcnt_f%0d", f), {16'd0, fcnt}, f);
                end
                // stimulus changes, applied after this cycle's sampling
                if (f == 1 && r == 0) begin
                    mode  = 2'b10;
                    color = 16'h1234;
                end
                if (f == 2 && v == VA + 10 && h == HA) color = 16'hABCD;
                if (f == 3 && r == 0) mode = 2'b11;
                if (f == 4 && v == VA + 20 && h == HA) en = 1'b0;
            end else begin
                if (hs || vs || de || (data != 16'h0000)) idle_bad++;
            end
            prev_hs = hs;
            prev_vs = vs;
            prev_de = de;
        end

        check_val("hs_high_frame0", hs_hi0, H_SYNC * VT);
        check_val("vs_high_frame0", vs_hi0, V_SYNC * HT);
        for (int i = 0; i < NFRAMES; i++) begin
            check_val($sformatf("de_total_f%0d", i), de_total[i], H_DISP * V_DISP);
            check_val($sformatf("de_bursts_f%0d", i), bursts[i], V_DISP);
        end
        check_val("de_burst_len", bad_burst, 0);
        check_val("idle_outputs", idle_bad, 0);
        check_val("fcnt_retained", {16'd0, fcnt}, 32'd5);

        // reset in the middle of an active line
        en = 1'b1;
        tick();
        for (int i = 0; i <= (VA + 1) * HT + HA + 20; i++) tick();
        check_val("pre_rst_de", {31'd0, de}, 32'd1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_de", {31'd0, de}, 32'd0);
        check_val("mid_rst_data", {16'd0, data}, 32'd0);
        check_val("mid_rst_fcnt", {16'd0, fcnt}, 32'd0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        en  = 1'b1;
        tick();
        check_val("restart_first_hs", {31'd0, hs}, 32'd0);
        tick();
        check_val("restart_hs", {31'd0, hs}, 32'd1);
        check_val("restart_vs", {31'd0, vs}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
